// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: circular sample buffer with a masked, mode-selectable
// trigger, a programmable pre-trigger window and oldest-first random-access readout.
module la_capture_core #(
    parameter int DATA_W = 96,
    parameter int TRIG_W = 8,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask,
    input  logic [TRIG_W-1:0] trig_value,
    input  logic [1:0]        trig_mode,
    input  logic [AW-1:0]     pretrig,
    input  logic              arm,
    input  logic              abort,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [AW-1:0]     trig_addr
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [AW-1:0]       r_wr_ptr, r_cnt, r_trig_addr, r_pretrig;
    logic [TRIG_W-1:0]   r_mask, r_value, r_prev_trig;
    logic [1:0]          r_mode;
    logic                r_prev_match, r_triggered;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_busy, w_arm_ok, w_write, w_match, w_change, w_cond, w_fire;
    logic                w_pre_last, w_post_last;
    logic [TRIG_W-1:0]   w_mask_eff, w_value_eff;
    logic [AW-1:0]       w_rd_phys;

    assign w_busy   = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_arm_ok = arm && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_write  = w_busy && !abort;

    // On the arm edge prev_match is computed with the configuration being armed, so
    // match-entry mode sees a consistent history when pretrig is zero.
    assign w_mask_eff  = w_arm_ok ? trig_mask  : r_mask;
    assign w_value_eff = w_arm_ok ? trig_value : r_value;
    assign w_match     = ((trig_i ^ w_value_eff) & w_mask_eff) == '0;
    assign w_change    = ((trig_i ^ r_prev_trig) & r_mask) != '0;

    always_comb begin
        w_cond = 1'b0;
        case (r_mode)
            2'b00:   w_cond = w_match;
            2'b01:   w_cond = w_match && !r_prev_match;
            2'b10:   w_cond = w_change;
            default: w_cond = 1'b1;
        endcase
    end

    assign w_fire      = (r_state == S_WAIT) && !abort && w_cond;
    assign w_pre_last  = r_cnt == (r_pretrig - AW'(1));
    assign w_post_last = r_cnt == (AW'(DEPTH - 2) - r_pretrig);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm && abort)         w_next = S_IDLE;
                else if (arm)             w_next = (pretrig != '0) ? S_PRE : S_WAIT;
            end
            S_PRE: begin
                if (abort)                w_next = S_IDLE;
                else if (w_pre_last)      w_next = S_WAIT;
            end
            S_WAIT: begin
                if (abort)                w_next = S_IDLE;
                else if (w_cond)          w_next = (r_pretrig == AW'(DEPTH - 1)) ? S_DONE : S_POST;
            end
            S_POST: begin
                if (abort)                w_next = S_IDLE;
                else if (w_post_last)     w_next = S_DONE;
            end
            default:                      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_trig_addr  <= '0;
            r_pretrig    <= '0;
            r_mask       <= '0;
            r_value      <= '0;
            r_mode       <= '0;
            r_prev_match <= 1'b0;
            r_prev_trig  <= '0;
            r_triggered  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_prev_match <= w_match;
            r_prev_trig  <= trig_i;
            if (w_arm_ok) begin
                r_mask      <= trig_mask;
                r_value     <= trig_value;
                r_mode      <= trig_mode;
                r_pretrig   <= pretrig;
                r_wr_ptr    <= '0;
                r_cnt       <= '0;
                r_triggered <= 1'b0;
            end else begin
                if (w_write)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (((r_state == S_PRE) || (r_state == S_POST)) && !abort)
                    r_cnt <= r_cnt + AW'(1);
                if (w_fire) begin
                    r_trig_addr <= r_wr_ptr;
                    r_triggered <= 1'b1;
                    r_cnt       <= '0;
                end
            end
        end
    end

    // Sample RAM: one write port, one registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wr_ptr] <= data_i;
    end

    assign w_rd_phys = (r_state == S_DONE) ? (r_trig_addr - r_pretrig + rd_addr) : rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_data <= '0;
        else     r_rd_data <= r_mem[w_rd_phys];
    end

    assign rd_data   = r_rd_data;
    assign busy      = w_busy;
    assign triggered = r_triggered;
    assign done      = (r_state == S_DONE);
    assign trig_addr = r_trig_addr;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed and randomized captures checked against a history-based model of the
// trigger rules: expected trigger edge, completion edge, trigger address and readout.
module tb_la_capture_core;

    localparam int DW    = 16;
    localparam int TW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int HIST  = 16384;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_i;
    logic [TW-1:0] trig_i, trig_mask, trig_value;
    logic [1:0]    trig_mode;
    logic [AW-1:0] pretrig, rd_addr, trig_addr;
    logic          arm, abort, busy, triggered, done;
    logic [DW-1:0] rd_data;

    int checks = 0;
    int errors = 0;
    int e = 0;
    logic [DW-1:0] hist_data [HIST];
    logic [TW-1:0] hist_trig [HIST];
    logic ovr = 1'b0;
    logic b7  = 1'b0;

    la_capture_core #(.DATA_W(DW), .TRIG_W(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .trig_i(trig_i),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_mode(trig_mode),
        .pretrig(pretrig), .arm(arm), .abort(abort), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .triggered(triggered), .done(done),
        .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // data_i is the index of the edge that will sample it; trig_i follows its low byte
    // unless bit 7 is being held by hand.
    task automatic apply_in();
        data_i = e[15:0];
        trig_i = ovr ? {b7, e[6:0]} : e[7:0];
    endtask

    task automatic step();
        hist_data[e % HIST] = data_i;
        hist_trig[e % HIST] = trig_i;
        @(posedge clk);
        #1;
        e++;
        apply_in();
    endtask

    function automatic bit mt(input int ee, input logic [7:0] mk, input logic [7:0] vl);
        return ((hist_trig[ee % HIST] ^ vl) & mk) == 8'h00;
    endfunction

    function automatic bit cond(input int ee, input logic [1:0] md, input logic [7:0] mk,
                                input logic [7:0] vl);
        case (md)
            2'b00:   return mt(ee, mk, vl);
            2'b01:   return mt(ee, mk, vl) && !mt(ee - 1, mk, vl);
            2'b10:   return ((hist_trig[ee % HIST] ^ hist_trig[(ee - 1) % HIST]) & mk) != 8'h00;
            default: return 1'b1;
        endcase
    endfunction

    // Offsets (k, counted in edges after the arm edge) select optional events; -1 = none.
    task automatic capture(input string tag, input int p, input logic [1:0] md,
                           input logic [7:0] mk, input logic [7:0] vl, input int abort_off,
                           input int arm_off, input int toggle_off, input int rst_off);
        int a, tdut, dn, ab, t_exp, last;
        bit fin;
        tdut = -1; dn = -1; ab = -1; t_exp = -1; fin = 1'b0;
        trig_mask = mk; trig_value = vl; trig_mode = md; pretrig = AW'(p);
        arm = 1'b1;
        a = e;
        step();
        arm = 1'b0;
        trig_mask = 8'($urandom); trig_value = 8'($urandom);
        trig_mode = 2'($urandom); pretrig = 4'($urandom);
        chk({tag, "_busy_after_arm"}, {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 700 && !fin; k++) begin
            if (k == toggle_off) begin b7 = ~b7; apply_in(); end
            if (k == abort_off) abort = 1'b1;
            if (k == arm_off) arm = 1'b1;
            step();
            abort = 1'b0; arm = 1'b0;
            if (triggered === 1'b1 && tdut < 0) tdut = e - 1;
            if (k == rst_off) begin
                #2 rst = 1'b1;
                #1;
                chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                chk({tag, "_rst_done"}, {31'd0, done}, 32'd0);
                chk({tag, "_rst_trig"}, {31'd0, triggered}, 32'd0);
                chk({tag, "_rst_taddr"}, {28'd0, trig_addr}, 32'd0);
                chk({tag, "_rst_rdata"}, {16'd0, rd_data}, 32'd0);
                #1 rst = 1'b0;
                return;
            end else if (k == abort_off) begin
                ab = e - 1; fin = 1'b1;
            end else if (done === 1'b1) begin
                dn = e - 1; fin = 1'b1;
            end
        end
        chk({tag, "_finished"}, {31'd0, fin}, 32'd1);
        if (!fin) return;
        last = e - 1;
        for (int ee = a + 1 + p; ee <= last; ee++) begin
            if (cond(ee, md, mk, vl)) begin t_exp = ee; break; end
        end
        if (ab >= 0) begin
            chk({tag, "_abort_trig"}, {31'd0, triggered}, {31'd0, (t_exp >= 0 && t_exp < ab)});
            chk({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_abort_done"}, {31'd0, done}, 32'd0);
            step();
            chk({tag, "_abort_stays_idle"}, {31'd0, busy}, 32'd0);
            return;
        end
        chk({tag, "_trig_edge"}, tdut, t_exp);
        chk({tag, "_done_edge"}, dn, t_exp + DEPTH - 1 - p);
        chk({tag, "_trig_addr"}, {28'd0, trig_addr}, (t_exp - a - 1) & (DEPTH - 1));
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_triggered"}, {31'd0, triggered}, 32'd1);
        if (t_exp < 0) return;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            step();
            chk($sformatf("%s_rd%0d", tag, i), {16'd0, rd_data},
                {16'd0, hist_data[(t_exp - p + i) % HIST]});
        end
    endtask

    task automatic idle_until(input int target);
        while (e < target) step();
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_addr = '0;
        trig_mask = '0; trig_value = '0; trig_mode = '0; pretrig = '0;
        apply_in();
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_triggered", {31'd0, triggered}, 32'd0);
        chk("reset_trig_addr", {28'd0, trig_addr}, 32'd0);
        chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
        #3 rst = 1'b0;
        step(); step();

        capture("level_0x30", 4, 2'b00, 8'hFF, 8'h30, -1, -1, -1, -1);
        idle_until(16'h110);
        capture("immediate_arm10", 4, 2'b11, 8'hFF, 8'h00, -1, -1, -1, -1);
        capture("immediate_p0", 0, 2'b11, 8'h00, 8'h00, -1, -1, -1, -1);
        capture("immediate_p15", 15, 2'b11, 8'h00, 8'h00, -1, -1, -1, -1);

        ovr = 1'b1; b7 = 1'b0; apply_in();
        capture("change_bit7", 2, 2'b10, 8'h80, 8'h00, -1, -1, 8, -1);
        ovr = 1'b0; apply_in();

        while (e[3:0] != 4'd4) step();
        capture("entry_already_true", 1, 2'b01, 8'hF0, 8'(e + 2) & 8'hF0, -1, -1, -1, -1);

        capture("abort_wait", 3, 2'b00, 8'hFF, 8'(e + 100), 10, -1, -1, -1);
        capture("abort_on_trigger", 2, 2'b11, 8'h00, 8'h00, 3, -1, -1, -1);
        capture("abort_post", 2, 2'b11, 8'h00, 8'h00, 6, -1, -1, -1);
        capture("abort_with_arm", 3, 2'b00, 8'hFF, 8'(e + 100), 5, 5, -1, -1);
        capture("arm_while_busy", 4, 2'b00, 8'hFF, 8'(e + 20), -1, 7, -1, -1);
        capture("rearm_from_done", 6, 2'b00, 8'hFF, 8'(e + 12), -1, -1, -1, -1);

        capture("rst_mid_post", 2, 2'b11, 8'h00, 8'h00, -1, -1, -1, 8);
        capture("after_rst_wrap", 5, 2'b00, 8'hFF, 8'(e + 40), -1, -1, -1, -1);

        for (int n = 0; n < 6; n++) begin
            int p_r, wait_r;
            logic [1:0] md_r;
            logic [7:0] mk_r, vl_r;
            wait_r = $urandom_range(0, 5);
            for (int w = 0; w < wait_r; w++) step();
            p_r  = $urandom_range(0, DEPTH - 1);
            md_r = 2'($urandom);
            mk_r = 8'($urandom_range(1, 255));
            vl_r = 8'($urandom);
            capture($sformatf("random%0d", n), p_r, md_r, mk_r, vl_r, -1, -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
